// File: rtl/regfile_write_scheduler.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B) producers,
// with a per-register pending-write scoreboard that drives busy_mask for RAW stalls.
module regfile_write_scheduler #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [2:0]        a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [2:0]        b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              issue_valid,
   input  logic [2:0]        issue_addr,
   output logic              issue_ready,
   output logic              wr_en,
   output logic [2:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [7:0]        busy_mask
);

   localparam int unsigned NREG = 8;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic RR_A = 1'b0;
   localparam logic RR_B = 1'b1;

   logic              rr_last_q, rr_last_d;
   logic              wr_en_q, wr_en_d;
   logic [2:0]        wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [CNT_W-1:0]  cnt_q [NREG];
   logic [CNT_W-1:0]  cnt_d [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic [NREG-1:0]   inc_c, dec_c;
   logic              grant_a_c, grant_b_c, issue_fire_c;

   // Arbitration: the port that did not win last time takes priority on contention
   always_comb begin
      grant_a_c = 1'b0;
      grant_b_c = 1'b0;
      if (a_valid && b_valid) begin
         if (rr_last_q == RR_B) grant_a_c = 1'b1;
         else                   grant_b_c = 1'b1;
      end else begin
         grant_a_c = a_valid;
         grant_b_c = b_valid;
      end
   end

   assign a_ready = grant_a_c;
   assign b_ready = grant_b_c;

   // A same-cycle commit to the reserved register frees one slot, so saturation can be bypassed
   assign issue_ready  = (cnt_q[issue_addr] != CNT_MAX) || (wr_en_q && (wr_addr_q == issue_addr));
   assign issue_fire_c = issue_valid && issue_ready;

   // Next write command and round-robin pointer
   always_comb begin
      rr_last_d = rr_last_q;
      wr_en_d   = grant_a_c || grant_b_c;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (grant_a_c) begin
         rr_last_d = RR_A;
         wr_addr_d = a_addr;
         wr_data_d = a_data;
      end else if (grant_b_c) begin
         rr_last_d = RR_B;
         wr_addr_d = b_addr;
         wr_data_d = b_data;
      end
   end

   // Scoreboard: reserve on issue, release on commit; underflow saturates at zero
   always_comb begin
      inc_c  = '0;
      dec_c  = '0;
      busy_d = '0;
      for (int i = 0; i < NREG; i++) begin
         inc_c[i] = issue_fire_c && (issue_addr == 3'(i));
         dec_c[i] = wr_en_q && (wr_addr_q == 3'(i));
         cnt_d[i] = cnt_q[i];
         if (inc_c[i] && !dec_c[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (dec_c[i] && !inc_c[i] && (cnt_q[i] != CNT_ZERO)) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
         busy_d[NREG-1-i] = (cnt_d[i] != CNT_ZERO);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last_q <= RR_B;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= '0;
         for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      end else begin
         assert (!(wr_en_q && (cnt_q[wr_addr_q] == CNT_ZERO)));
         rr_last_q <= rr_last_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy_mask = busy_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed self-checking bench for regfile_write_scheduler: arbitration order, write latency,
// scoreboard saturation/bypass, same-address serialization and reset in a grant cycle.
module tb_regfile_write_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_valid, b_valid, issue_valid;
   logic [2:0] a_addr, b_addr, issue_addr;
   logic [7:0] a_data, b_data;
   logic       a_ready, b_ready, issue_ready, wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data, busy_mask;

   int checks   = 0;
   int failures = 0;

   regfile_write_scheduler #(.DATA_W(8), .CNT_W(2)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_mask(busy_mask)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      a_valid     = 1'b0;
      b_valid     = 1'b0;
      issue_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b1;
      idle();
      a_addr = '0; b_addr = '0; issue_addr = '0;
      a_data = '0; b_data = '0;
      tick(); tick(); settle();

      // Reset state, no traffic
      chk("rst_wr_en",       32'(wr_en),       32'h0);
      chk("rst_busy",        32'(busy_mask),   32'h00);
      chk("rst_issue_ready", 32'(issue_ready), 32'h1);
      chk("rst_a_ready",     32'(a_ready),     32'h0);
      chk("rst_b_ready",     32'(b_ready),     32'h0);
      chk("rst_wr_addr",     32'(wr_addr),     32'h0);
      chk("rst_wr_data",     32'(wr_data),     32'h0);
      reset = 1'b0;
      tick(); settle();
      chk("idle_wr_en", 32'(wr_en), 32'h0);

      // Reserve r3, then A writes A5 to r3
      issue_valid = 1'b1; issue_addr = 3'd3; settle();
      chk("t2_issue_ready", 32'(issue_ready), 32'h1);
      tick();
      issue_valid = 1'b0;
      a_valid = 1'b1; a_addr = 3'd3; a_data = 8'hA5; settle();
      chk("t2_busy_pending", 32'(busy_mask), 32'h10);
      chk("t2_a_ready",      32'(a_ready),   32'h1);
      chk("t2_b_ready",      32'(b_ready),   32'h0);
      chk("t2_wr_en_pre",    32'(wr_en),     32'h0);
      tick();
      a_valid = 1'b0; settle();
      chk("t2_wr_en",      32'(wr_en),     32'h1);
      chk("t2_wr_addr",    32'(wr_addr),   32'h3);
      chk("t2_wr_data",    32'(wr_data),   32'hA5);
      chk("t2_busy_until", 32'(busy_mask), 32'h10);
      tick(); settle();
      chk("t2_wr_en_off",    32'(wr_en),     32'h0);
      chk("t2_busy_clear",   32'(busy_mask), 32'h00);
      chk("t2_wr_addr_hold", 32'(wr_addr),   32'h3);
      chk("t2_wr_data_hold", 32'(wr_data),   32'hA5);

      // Fresh reset so A has priority, then alternating grants with both ports valid
      reset = 1'b1; tick(); reset = 1'b0;
      issue_valid = 1'b1; issue_addr = 3'd1; tick(); tick();
      issue_addr = 3'd2; tick(); tick();
      issue_valid = 1'b0;
      a_valid = 1'b1; a_addr = 3'd1; a_data = 8'h01;
      b_valid = 1'b1; b_addr = 3'd2; b_data = 8'h02; settle();
      chk("t3_busy", 32'(busy_mask), 32'h60);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t3_a_ready_%0d", k), 32'(a_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("t3_b_ready_%0d", k), 32'(b_ready), (k % 2 == 1) ? 32'h1 : 32'h0);
         if (k > 0) begin
            chk($sformatf("t3_wr_en_%0d", k),   32'(wr_en),   32'h1);
            chk($sformatf("t3_wr_addr_%0d", k), 32'(wr_addr), (k % 2 == 1) ? 32'h1 : 32'h2);
         end
         tick();
         if (k == 3) idle();
         settle();
      end
      chk("t3_wr_en_last",   32'(wr_en),     32'h1);
      chk("t3_wr_addr_last", 32'(wr_addr),   32'h2);
      chk("t3_wr_data_last", 32'(wr_data),   32'h02);
      chk("t3_busy_last",    32'(busy_mask), 32'h20);
      tick(); settle();
      chk("t3_wr_en_off", 32'(wr_en),     32'h0);
      chk("t3_busy_done", 32'(busy_mask), 32'h00);

      // A and B both target r5: A first (last grant was B), B's data ends in the register
      issue_valid = 1'b1; issue_addr = 3'd5; tick(); tick();
      issue_valid = 1'b0;
      a_valid = 1'b1; a_addr = 3'd5; a_data = 8'h11;
      b_valid = 1'b1; b_addr = 3'd5; b_data = 8'h22; settle();
      chk("t5_busy",    32'(busy_mask), 32'h04);
      chk("t5_a_ready", 32'(a_ready),   32'h1);
      chk("t5_b_ready", 32'(b_ready),   32'h0);
      tick();
      a_valid = 1'b0; settle();
      chk("t5_b_ready2",  32'(b_ready), 32'h1);
      chk("t5_wr1_addr",  32'(wr_addr), 32'h5);
      chk("t5_wr1_data",  32'(wr_data), 32'h11);
      tick();
      b_valid = 1'b0; settle();
      chk("t5_wr2_en",    32'(wr_en),     32'h1);
      chk("t5_wr2_addr",  32'(wr_addr),   32'h5);
      chk("t5_wr2_data",  32'(wr_data),   32'h22);
      chk("t5_wr2_busy",  32'(busy_mask), 32'h04);
      tick(); settle();
      chk("t5_wr_en_off", 32'(wr_en),     32'h0);
      chk("t5_final",     32'(wr_data),   32'h22);
      chk("t5_busy_done", 32'(busy_mask), 32'h00);

      // Saturate r7 at 3 reservations, bypass with a same-cycle commit, then drain
      issue_valid = 1'b1; issue_addr = 3'd7;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk($sformatf("t4_issue_ready_%0d", k), 32'(issue_ready), 32'h1);
         tick();
      end
      a_valid = 1'b1; a_addr = 3'd7; a_data = 8'h77; settle();
      chk("t4_busy_full",    32'(busy_mask),   32'h01);
      chk("t4_issue_sat",    32'(issue_ready), 32'h0);
      chk("t4_a_ready",      32'(a_ready),     32'h1);
      tick();
      a_valid = 1'b0; settle();
      chk("t4_bypass_wr_en", 32'(wr_en),       32'h1);
      chk("t4_bypass_addr",  32'(wr_addr),     32'h7);
      chk("t4_bypass_ready", 32'(issue_ready), 32'h1);
      tick();
      issue_valid = 1'b0; settle();
      chk("t4_busy_still",   32'(busy_mask),   32'h01);
      chk("t4_issue_sat2",   32'(issue_ready), 32'h0);
      a_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk($sformatf("t4_drain_ready_%0d", k), 32'(a_ready), 32'h1);
         tick();
      end
      a_valid = 1'b0; settle();
      chk("t4_drain_wr_en", 32'(wr_en),     32'h1);
      chk("t4_drain_busy",  32'(busy_mask), 32'h01);
      tick(); settle();
      chk("t4_busy_clear",  32'(busy_mask), 32'h00);
      chk("t4_wr_en_off",   32'(wr_en),     32'h0);

      // Fill every register, then reset during a grant cycle
      issue_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         issue_addr = 3'(i);
         tick();
      end
      issue_valid = 1'b0; settle();
      chk("t6_busy_ff", 32'(busy_mask), 32'hFF);
      a_valid = 1'b1; a_addr = 3'd0; a_data = 8'h99;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_valid = 1'b1; a_addr = 3'd0; a_data = 8'h5A;
      b_valid = 1'b1; b_addr = 3'd1; b_data = 8'h66;
      issue_valid = 1'b1; issue_addr = 3'd0; settle();
      chk("t6_wr_en",       32'(wr_en),       32'h0);
      chk("t6_busy",        32'(busy_mask),   32'h00);
      chk("t6_wr_addr",     32'(wr_addr),     32'h0);
      chk("t6_wr_data",     32'(wr_data),     32'h00);
      chk("t6_rr_a_ready",  32'(a_ready),     32'h1);
      chk("t6_rr_b_ready",  32'(b_ready),     32'h0);
      chk("t6_issue_ready", 32'(issue_ready), 32'h1);
      tick();
      idle(); settle();
      chk("t6_post_wr_en",   32'(wr_en),     32'h1);
      chk("t6_post_wr_addr", 32'(wr_addr),   32'h0);
      chk("t6_post_wr_data", 32'(wr_data),   32'h5A);
      chk("t6_post_busy",    32'(busy_mask), 32'h80);
      tick(); settle();
      chk("t6_end_wr_en", 32'(wr_en),     32'h0);
      chk("t6_end_busy",  32'(busy_mask), 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
